std_fp_div_arbiter: RTL and testbench

//  Shares one multi-cycle fixed-point divider core among NUM_REQ requesters.

---
 rtl/std_fp_div_arb_pkg.sv | 22 ++
 rtl/std_fp_div_arbiter_if.sv | 36 +++
 rtl/std_rr_arbiter.sv | 31 +++
 rtl/std_fp_div_arbiter.sv | 132 +++++++++++++
 tb/tb_std_fp_div_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/std_fp_div_arb_pkg.sv
// Shared types for the divider arbiter: controller states, error codes and
// the requester-id width helper.
package std_fp_div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DIV0    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    // Bits needed to name one of n requesters; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/std_fp_div_arbiter_if.sv
// Requester, response and divider-core signals of the shared divider arbiter.
// slave is the arbiter's view; master is the lanes-plus-core side.
interface std_fp_div_arbiter_if #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_left;
    logic [NUM_REQ*WIDTH-1:0] req_right;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]         rsp_quotient;
    logic [WIDTH-1:0]         rsp_remainder;
    logic [1:0]               rsp_err;
    logic                     div_go;
    logic [WIDTH-1:0]         div_left;
    logic [WIDTH-1:0]         div_right;
    logic                     div_done;
    logic [WIDTH-1:0]         div_quotient;
    logic [WIDTH-1:0]         div_remainder;

    modport slave (
        input  req_valid, req_left, req_right, rsp_ready,
               div_done, div_quotient, div_remainder,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
               div_go, div_left, div_right
    );

    modport master (
        output req_valid, req_left, req_right, rsp_ready,
               div_done, div_quotient, div_remainder,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
               div_go, div_left, div_right
    );
endinterface

// File: rtl/std_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping. The pointer register lives in the parent.
module std_rr_arbiter
    import std_fp_div_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/std_fp_div_arbiter.sv
// Shares one multi-cycle fixed-point divider among NUM_REQ requesters, with
// divide-by-zero short-circuit and a watchdog against a hung core.
module std_fp_div_arbiter
    import std_fp_div_arb_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned FRAC_WIDTH     = 2,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    std_fp_div_arbiter_if.slave bus
);

    localparam int unsigned ID_W = id_w(NUM_REQ);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    if (TIMEOUT_CYCLES < WIDTH + FRAC_WIDTH + 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES shorter than the core's worst-case latency");
    end

    state_e             state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] owner_oh;
    logic [WD_W-1:0]    wd;
    logic               div_go_q;
    logic [WIDTH-1:0]   div_left_q;
    logic [WIDTH-1:0]   div_right_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [WIDTH-1:0]   rsp_quotient_q;
    logic [WIDTH-1:0]   rsp_remainder_q;
    err_e               rsp_err_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [WIDTH-1:0]   grant_left;
    logic [WIDTH-1:0]   grant_right;
    logic [ID_W-1:0]    next_ptr;

    std_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (bus.req_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        grant_left  = bus.req_left[grant_idx*WIDTH +: WIDTH];
        grant_right = bus.req_right[grant_idx*WIDTH +: WIDTH];
        next_ptr    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    assign bus.req_ready     = (state == IDLE) ? grant : '0;
    assign bus.div_go        = div_go_q;
    assign bus.div_left      = div_left_q;
    assign bus.div_right     = div_right_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_quotient  = rsp_quotient_q;
    assign bus.rsp_remainder = rsp_remainder_q;
    assign bus.rsp_err       = rsp_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            ptr             <= '0;
            owner_oh        <= '0;
            wd              <= '0;
            div_go_q        <= 1'b0;
            div_left_q      <= '0;
            div_right_q     <= '0;
            rsp_valid_q     <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_err_q       <= ERR_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_oh <= grant;
                        ptr      <= next_ptr;
                        if (grant_right == '0) begin
                            // Answer directly; the core never sees a zero divisor.
                            state           <= RESP;
                            rsp_valid_q     <= grant;
                            rsp_quotient_q  <= '1;
                            rsp_remainder_q <= grant_left;
                            rsp_err_q       <= ERR_DIV0;
                        end else begin
                            state       <= BUSY;
                            div_go_q    <= 1'b1;
                            div_left_q  <= grant_left;
                            div_right_q <= grant_right;
                            wd          <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.div_done) begin
                        state           <= RESP;
                        div_go_q        <= 1'b0;
                        rsp_valid_q     <= owner_oh;
                        rsp_quotient_q  <= bus.div_quotient;
                        rsp_remainder_q <= bus.div_remainder;
                        rsp_err_q       <= ERR_NONE;
                    end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state           <= RESP;
                        div_go_q        <= 1'b0;
                        rsp_valid_q     <= owner_oh;
                        rsp_quotient_q  <= '0;
                        rsp_remainder_q <= '0;
                        rsp_err_q       <= ERR_TIMEOUT;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                RESP: begin
                    if (|(bus.rsp_ready & owner_oh)) begin
                        state       <= IDLE;
                        rsp_valid_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_std_fp_div_arbiter.sv
// Directed bench for std_fp_div_arbiter with a transaction-level model of
// arbitration and result routing, a behavioural divider core, and literal pins.
module tb_std_fp_div_arbiter;

    localparam int W = 4;
    localparam int N = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    std_fp_div_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    std_fp_div_arbiter #(
        .WIDTH          (W),
        .FRAC_WIDTH     (2),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fixed-point divide with 2 fractional bits, truncated to W bits.
    function automatic logic [W-1:0] fpq(input logic [W-1:0] l, input logic [W-1:0] r);
        int n;
        n = int'(l) << 2;
        return (r == 0) ? '0 : W'(n / int'(r));
    endfunction

    function automatic logic [W-1:0] fpr(input logic [W-1:0] l, input logic [W-1:0] r);
        int n;
        n = int'(l) << 2;
        return (r == 0) ? '0 : W'(n % int'(r));
    endfunction

    // Divider core model
    int   core_lat = 2;
    logic core_hang = 1'b0;
    logic inject_done = 1'b0;

    initial begin
        int busy;
        logic pulse;
        busy = 0;
        bus.div_done = 1'b0;
        bus.div_quotient = '0;
        bus.div_remainder = '0;
        forever begin
            @(posedge clk);
            #2;
            busy = bus.div_go ? busy + 1 : 0;
            pulse = bus.div_go && !core_hang && (busy == core_lat);
            bus.div_done = pulse || inject_done;
            if (pulse) begin
                bus.div_quotient = fpq(bus.div_left, bus.div_right);
                bus.div_remainder = fpr(bus.div_left, bus.div_right);
            end else if (inject_done) begin
                bus.div_quotient = 4'b1010;
                bus.div_remainder = 4'b0101;
            end
        end
    end

    // Transaction model and per-cycle compare
    logic         m_busy = 1'b0;
    int           m_ptr = 0;
    int           op_id, since, go_cycles;
    logic [W-1:0] op_l, op_r;
    logic         op_div0, op_hang, in_rsp, prev_done;
    int           grant_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("reset_div_go", 32'(bus.div_go), 0);
            chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
            m_busy = 0;
            m_ptr = 0;
            in_rsp = 0;
        end else begin
            if (!m_busy) begin
                logic [N-1:0] exp_g;
                int pick;
                exp_g = '0;
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && bus.req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                if (pick >= 0) exp_g[pick] = 1'b1;
                chk("req_ready", 32'(bus.req_ready), 32'(exp_g));
                if (pick >= 0) begin
                    m_busy = 1;
                    op_id = pick;
                    op_l = bus.req_left[pick*W +: W];
                    op_r = bus.req_right[pick*W +: W];
                    op_div0 = (op_r == 0);
                    op_hang = core_hang;
                    since = 0;
                    go_cycles = 0;
                    in_rsp = 0;
                    prev_done = 0;
                    grant_log.push_back(pick);
                    m_ptr = (pick + 1) % N;
                end
            end else begin
                chk("req_ready_held", 32'(bus.req_ready), 0);
            end

            if (m_busy) begin
                if (since == 0) chk("go_in_grant_cycle", 32'(bus.div_go), 0);
                if (since == 1 && !op_div0) chk("go_cycle1", 32'(bus.div_go), 1);
                if (bus.div_go) begin
                    go_cycles++;
                    chk("go_div0", 32'(op_div0), 0);
                    chk("go_left", 32'(bus.div_left), 32'(op_l));
                    chk("go_right", 32'(bus.div_right), 32'(op_r));
                    chk("go_with_rsp", 32'(bus.rsp_valid), 0);
                end
                if (bus.rsp_valid != 0) begin
                    logic [W-1:0] eq, er;
                    logic [1:0] ee;
                    if (op_div0) begin
                        eq = '1; er = op_l; ee = 2'd1;
                    end else if (op_hang) begin
                        eq = '0; er = '0; ee = 2'd2;
                    end else begin
                        eq = fpq(op_l, op_r); er = fpr(op_l, op_r); ee = 2'd0;
                    end
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << op_id);
                    chk("rsp_quotient", 32'(bus.rsp_quotient), 32'(eq));
                    chk("rsp_remainder", 32'(bus.rsp_remainder), 32'(er));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
                    if (!in_rsp) begin
                        if (op_div0) chk("div0_latency", since, 1);
                        else if (op_hang) chk("timeout_go_cycles", go_cycles, TMO);
                        else chk("rsp_after_done", 32'(prev_done), 1);
                        in_rsp = 1;
                    end
                    if (bus.rsp_ready[op_id]) begin
                        m_busy = 0;
                        in_rsp = 0;
                    end
                end else begin
                    chk("rsp_dropped", 32'(in_rsp), 0);
                end
                prev_done = bus.div_go && bus.div_done;
                since++;
            end else begin
                chk("idle_div_go", 32'(bus.div_go), 0);
                chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
            end
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
        bus.req_left[i*W +: W] = l;
        bus.req_right[i*W +: W] = r;
    endtask

    // Returns at cycle 1 (+1 time unit) after the grant of requester i.
    task automatic wait_grant(input int i);
        int n;
        n = 0;
        #1;
        while (!bus.req_ready[i] && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("grant_seen", 32'(bus.req_ready[i]), 1);
        tick();
    endtask

    task automatic wait_rsp(input int i);
        int n;
        n = 0;
        while (!bus.rsp_valid[i] && n < 60) begin
            tick();
            n++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid[i]), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || bus.rsp_valid != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(n < 100), 1);
    endtask

    task automatic load_all();
        set_op(0, 4'b0110, 4'b0100);
        set_op(1, 4'b0000, 4'b0011);
        set_op(2, 4'b0011, 4'b0101);
        set_op(3, 4'b1111, 4'b0011);
    endtask

    initial begin
        int base, n;
        bus.req_valid = '0;
        bus.req_left = '0;
        bus.req_right = '0;
        bus.rsp_ready = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Round robin with all requesters active
        load_all();
        core_lat = 2;
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        chk("rr_count", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            chk("rr_order0", grant_log[0], 0);
            chk("rr_order1", grant_log[1], 1);
            chk("rr_order2", grant_log[2], 2);
            chk("rr_order3", grant_log[3], 3);
            chk("rr_order4", grant_log[4], 0);
        end
        wait_idle();

        // Single op with backpressure; a second request waits for the handshake
        bus.rsp_ready = '0;
        core_lat = 3;
        set_op(0, 4'b0110, 4'b0100);
        set_op(1, 4'b1000, 4'b0011);
        bus.req_valid = 4'b0001;
        wait_grant(0);
        bus.req_valid = 4'b0010;
        chk("t1_div_go_cycle1", 32'(bus.div_go), 1);
        wait_rsp(0);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("t1_quotient", 32'(bus.rsp_quotient), 32'b0110);
        chk("t1_remainder", 32'(bus.rsp_remainder), 0);
        chk("t1_err", 32'(bus.rsp_err), 0);
        repeat (3) begin
            tick();
            chk("t1_no_grant", 32'(bus.req_ready), 0);
        end
        bus.rsp_ready = '1;
        wait_grant(1);
        bus.req_valid = '0;
        wait_rsp(1);
        chk("t1b_quotient", 32'(bus.rsp_quotient), 32'b1010);
        chk("t1b_remainder", 32'(bus.rsp_remainder), 32'b0010);
        wait_idle();

        // Divide by zero
        bus.rsp_ready = '0;
        set_op(2, 4'b1011, 4'b0000);
        bus.req_valid = 4'b0100;
        wait_grant(2);
        bus.req_valid = '0;
        chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        chk("t3_quotient", 32'(bus.rsp_quotient), 32'b1111);
        chk("t3_remainder", 32'(bus.rsp_remainder), 32'b1011);
        chk("t3_err", 32'(bus.rsp_err), 1);
        chk("t3_div_go", 32'(bus.div_go), 0);
        tick();
        chk("t3_div_go_later", 32'(bus.div_go), 0);
        bus.rsp_ready = '1;
        wait_idle();

        // Hung core, long backpressure, late done pulse, then normal op
        bus.rsp_ready = '0;
        core_hang = 1'b1;
        set_op(3, 4'b0111, 4'b0010);
        set_op(0, 4'b0100, 4'b0010);
        bus.req_valid = 4'b1000;
        wait_grant(3);
        bus.req_valid = 4'b0001;
        wait_rsp(3);
        chk("t4_err", 32'(bus.rsp_err), 2);
        chk("t4_quotient", 32'(bus.rsp_quotient), 0);
        chk("t4_remainder", 32'(bus.rsp_remainder), 0);
        for (int c = 0; c < 5; c++) begin
            inject_done = (c == 1);
            tick();
            chk("t4_hold_ready", 32'(bus.req_ready), 0);
            chk("t4_hold_go", 32'(bus.div_go), 0);
            chk("t4_hold_valid", 32'(bus.rsp_valid), 32'b1000);
            chk("t4_hold_err", 32'(bus.rsp_err), 2);
        end
        inject_done = 1'b0;
        core_hang = 1'b0;
        core_lat = 1;
        bus.rsp_ready = '1;
        wait_grant(0);
        bus.req_valid = '0;
        chk("t4b_div_go", 32'(bus.div_go), 1);
        wait_rsp(0);
        chk("t4b_quotient", 32'(bus.rsp_quotient), 32'b1000);
        chk("t4b_err", 32'(bus.rsp_err), 0);
        wait_idle();

        // Reset during BUSY
        core_hang = 1'b1;
        set_op(2, 4'b0101, 4'b0001);
        bus.req_valid = 4'b0100;
        wait_grant(2);
        bus.req_valid = '0;
        repeat (3) tick();
        chk("t5_busy_go", 32'(bus.div_go), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_reset_go", 32'(bus.div_go), 0);
        chk("t5_reset_rsp", 32'(bus.rsp_valid), 0);
        repeat (2) tick();
        core_hang = 1'b0;
        core_lat = 2;
        load_all();
        reset_n = 1'b1;
        bus.req_valid = '1;
        base = grant_log.size();
        #1;
        chk("t5_first_grant", 32'(bus.req_ready), 32'b0001);
        n = 0;
        while (grant_log.size() < base + 3 && n < 200) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        chk("t5_grants", grant_log.size(), base + 3);
        wait_idle();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, %0d miscompares", miscompares);
        $fatal(1);
    end

endmodule
